cpu_phase_ctrl: RTL and testbench

Multi-cycle sequencer for the 8-bit bit_cpu datapath. It replaces the free-running second clock with explicit phase enables: IR load, PC update, register-file write and data-memory strobes. It adds run, single-step and halt control, and a wait-state handshake so the data memory can sit behind a slow, APB-style slave. It sits between the control decoder outputs (nia, reg_write, mem_read, mem_write), the ALU branch flag and the pc/regfile/datamem enables.

---
 rtl/cpu_ctrl_pkg.sv | 28 ++
 rtl/mem_wait_timer.sv | 36 +++
 rtl/cpu_phase_ctrl.sv | 143 ++++++++++++++
 tb/tb_cpu_phase_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared state encoding and PC-select constants for the bit_cpu phase controller.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_HALT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERR    = 3'd6
  } state_e;

  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_JMP = 2'b01;
  localparam logic [1:0] PC_BR  = 2'b10;

  // Jump (nia=0) outranks a taken branch.
  function automatic logic [1:0] branch_sel(input logic nia, input logic br);
    if (!nia) begin
      return PC_JMP;
    end else if (br) begin
      return PC_BR;
    end
    return PC_INC;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-state counter for the data-memory phase; flags expiry on the MEM_TIMEOUT-th cycle.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] Limit = 8'(MEM_TIMEOUT - 1);

  logic [7:0] cnt_q, cnt_d;

  // cnt_q counts cycles already spent, so expiry lands on the MEM_TIMEOUT-th cycle.
  assign expired = (cnt_q == Limit);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cpu_phase_ctrl.sv
// Multi-cycle phase sequencer for bit_cpu: fetch/decode/exec/mem/writeback enables,
// run/step/halt control and a bounded wait-state handshake to data memory.
module cpu_phase_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             step,
  input  logic             halt_req,
  input  logic             nia,
  input  logic             br,
  input  logic             reg_write,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             mem_ready,
  output logic             ir_load,
  output logic             pc_en,
  output logic [1:0]       pc_sel,
  output logic             rf_we,
  output logic             dmem_re,
  output logic             dmem_we,
  output logic             halted,
  output logic             busy,
  output logic             bus_err,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state_dbg
);

  state_e           state_q, state_d;
  logic             step_mode_q, step_mode_d;
  logic             rf_q, rf_d;
  logic             rd_q, rd_d;
  logic             wr_q, wr_d;
  logic [1:0]       sel_q, sel_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             timer_expired;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state_q != S_MEM),
    .en     (state_q == S_MEM),
    .expired(timer_expired)
  );

  always_comb begin
    state_d     = state_q;
    step_mode_d = step_mode_q;
    rf_d        = rf_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    sel_d       = sel_q;
    instret_d   = instret_q;
    case (state_q)
      S_HALT: begin
        if (halt_req) begin
          state_d = S_HALT;
        end else if (run) begin
          state_d = S_FETCH;
        end else if (step) begin
          state_d     = S_FETCH;
          step_mode_d = 1'b1;
        end
      end
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        rf_d  = reg_write;
        sel_d = branch_sel(nia, br);
        rd_d  = mem_read;
        wr_d  = mem_write;
        if (mem_read && mem_write) begin
          state_d = S_ERR;
        end else if (mem_read || mem_write) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        // A ready arriving on the timeout cycle still completes the access.
        if (mem_ready) begin
          state_d = S_WB;
        end else if (timer_expired) begin
          state_d = S_ERR;
        end
      end
      S_WB: begin
        instret_d = instret_q + CNT_W'(1);
        if (halt_req || step_mode_q || !run) begin
          state_d     = S_HALT;
          step_mode_d = 1'b0;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_HALT;
      step_mode_q <= 1'b0;
      rf_q        <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      sel_q       <= PC_INC;
      instret_q   <= '0;
    end else begin
      state_q     <= state_d;
      step_mode_q <= step_mode_d;
      rf_q        <= rf_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      sel_q       <= sel_d;
      instret_q   <= instret_d;
    end
  end

  always_comb begin
    ir_load = (state_q == S_FETCH);
    pc_en   = (state_q == S_WB);
    pc_sel  = (state_q == S_WB) ? sel_q : PC_INC;
    rf_we   = (state_q == S_WB) && rf_q;
    dmem_re = (state_q == S_MEM) && rd_q;
    dmem_we = (state_q == S_MEM) && wr_q;
    halted  = (state_q == S_HALT) || (state_q == S_ERR);
    busy    = !halted;
    bus_err = (state_q == S_ERR);
  end

  assign instret   = instret_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_cpu_phase_ctrl.sv
// Directed self-checking bench for cpu_phase_ctrl.
module tb_cpu_phase_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run, step, halt_req, nia, br, reg_write, mem_read, mem_write, mem_ready;
  logic        ir_load, pc_en, rf_we, dmem_re, dmem_we, halted, busy, bus_err;
  logic [1:0]  pc_sel;
  logic [15:0] instret;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  cpu_phase_ctrl #(
    .MEM_TIMEOUT(15),
    .CNT_W      (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .step     (step),
    .halt_req (halt_req),
    .nia      (nia),
    .br       (br),
    .reg_write(reg_write),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .mem_ready(mem_ready),
    .ir_load  (ir_load),
    .pc_en    (pc_en),
    .pc_sel   (pc_sel),
    .rf_we    (rf_we),
    .dmem_re  (dmem_re),
    .dmem_we  (dmem_we),
    .halted   (halted),
    .busy     (busy),
    .bus_err  (bus_err),
    .instret  (instret),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    {run, step, halt_req, br, reg_write, mem_read, mem_write, mem_ready} = '0;
    nia = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (state_dbg !== 3'd0) begin
      errors++; $display("FAIL reset_state: got %0d want 0", state_dbg);
    end
    checks++;
    if ({halted, busy, bus_err} !== 3'b100) begin
      errors++; $display("FAIL reset_status: got %b want 100", {halted, busy, bus_err});
    end
    checks++;
    if ({ir_load, pc_en, pc_sel, rf_we, dmem_re, dmem_we} !== 7'b0) begin
      errors++;
      $display("FAIL reset_enables: got %b want 0", {ir_load, pc_en, pc_sel, rf_we, dmem_re,
                                                      dmem_we});
    end
    checks++;
    if (instret !== 16'd0) begin
      errors++; $display("FAIL reset_instret: got %0d want 0", instret);
    end
    tick();
    checks++;
    if (state_dbg !== 3'd0) begin
      errors++; $display("FAIL idle_stays_halted: got %0d want 0", state_dbg);
    end
  endtask

  task automatic test_alu_op();
    run = 1'b1; nia = 1'b1; br = 1'b0; reg_write = 1'b1;
    mem_ready = 1'b1;  // ignored outside S_MEM
    tick();
    checks++;
    if ({ir_load, pc_en, busy} !== 3'b101) begin
      errors++; $display("FAIL alu_fetch: got %b want 101", {ir_load, pc_en, busy});
    end
    tick();
    tick();
    tick();
    checks++;
    if ({pc_en, pc_sel, rf_we, ir_load} !== 5'b10010) begin
      errors++; $display("FAIL alu_wb: got %b want 10010", {pc_en, pc_sel, rf_we, ir_load});
    end
    checks++;
    if (state_dbg !== 3'd5) begin
      errors++; $display("FAIL alu_wb_state: got %0d want 5", state_dbg);
    end
    tick();
    checks++;
    if (state_dbg !== 3'd1 || instret !== 16'd1) begin
      errors++; $display("FAIL alu_refetch: got st=%0d ir=%0d want st=1 ir=1", state_dbg, instret);
    end
    mem_ready = 1'b0;
    run = 1'b0;  // mid-instruction deassert still retires this one
    tick();
    tick();
    tick();
    checks++;
    if (pc_en !== 1'b1) begin
      errors++; $display("FAIL alu_run_drop_retires: got %b want 1", pc_en);
    end
    tick();
    checks++;
    if (state_dbg !== 3'd0 || instret !== 16'd2) begin
      errors++; $display("FAIL alu_halt_after: got st=%0d ir=%0d want st=0 ir=2", state_dbg, instret);
    end
  endtask

  task automatic test_jump_branch();
    run = 1'b1; nia = 1'b0; br = 1'b0; reg_write = 1'b0;
    repeat (4) tick();
    checks++;
    if ({pc_en, pc_sel, rf_we} !== 4'b1010) begin
      errors++; $display("FAIL jump_wb: got %b want 1010", {pc_en, pc_sel, rf_we});
    end
    nia = 1'b1; br = 1'b1; reg_write = 1'b1;
    repeat (4) tick();
    checks++;
    if ({pc_en, pc_sel, rf_we} !== 4'b1101) begin
      errors++; $display("FAIL branch_wb: got %b want 1101", {pc_en, pc_sel, rf_we});
    end
    run = 1'b0;
    tick();
    checks++;
    if (state_dbg !== 3'd0 || instret !== 16'd4) begin
      errors++; $display("FAIL branch_halt: got st=%0d ir=%0d want st=0 ir=4", state_dbg, instret);
    end
    br = 1'b0;
  endtask

  task automatic test_load_wait();
    int cycles;
    int re_cnt;
    int we_cnt;
    cycles = 0; re_cnt = 0; we_cnt = 0;
    run = 1'b1; nia = 1'b1; reg_write = 1'b1; mem_read = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      run = 1'b0;
      cycles++;
      if (dmem_re) re_cnt++;
      if (dmem_we) we_cnt++;
      mem_ready = (dmem_re && re_cnt == 4);  // ready on the 4th S_MEM cycle
      if (pc_en) break;
    end
    mem_ready = 1'b0;
    mem_read = 1'b0;
    checks++;
    if (cycles !== 8) begin
      errors++; $display("FAIL load_latency: got %0d want 8", cycles);
    end
    checks++;
    if (re_cnt !== 4 || we_cnt !== 0) begin
      errors++; $display("FAIL load_strobes: got re=%0d we=%0d want re=4 we=0", re_cnt, we_cnt);
    end
    checks++;
    if (dmem_re !== 1'b0 || rf_we !== 1'b1) begin
      errors++; $display("FAIL load_wb: got re=%b rf=%b want re=0 rf=1", dmem_re, rf_we);
    end
    tick();
    checks++;
    if (instret !== 16'd5 || state_dbg !== 3'd0) begin
      errors++; $display("FAIL load_retire: got ir=%0d st=%0d want ir=5 st=0", instret, state_dbg);
    end
  endtask

  task automatic test_store_timeout();
    int we_cnt;
    int pc_cnt;
    we_cnt = 0; pc_cnt = 0;
    run = 1'b1; reg_write = 1'b0; mem_write = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (dmem_we) we_cnt++;
      if (pc_en) pc_cnt++;
      if (halted) break;
    end
    checks++;
    if (we_cnt !== 15 || pc_cnt !== 0) begin
      errors++; $display("FAIL store_timeout_strobes: got we=%0d pc=%0d want we=15 pc=0", we_cnt, pc_cnt);
    end
    checks++;
    if ({bus_err, halted, busy, dmem_we} !== 4'b1100 || state_dbg !== 3'd6) begin
      errors++; $display("FAIL store_err: got %b st=%0d want 1100 st=6",
                         {bus_err, halted, busy, dmem_we}, state_dbg);
    end
    mem_write = 1'b0;
    step = 1'b1;
    repeat (3) tick();
    step = 1'b0;
    checks++;
    if (state_dbg !== 3'd6 || ir_load !== 1'b0 || bus_err !== 1'b1) begin
      errors++; $display("FAIL err_sticky: got st=%0d ir_load=%b err=%b want st=6 0 1",
                         state_dbg, ir_load, bus_err);
    end
    apply_reset();
    checks++;
    if (instret !== 16'd0 || bus_err !== 1'b0 || state_dbg !== 3'd0) begin
      errors++; $display("FAIL err_reset: got ir=%0d err=%b st=%0d want 0 0 0",
                         instret, bus_err, state_dbg);
    end
  endtask

  task automatic test_both_mem();
    run = 1'b1; mem_read = 1'b1; mem_write = 1'b1;
    repeat (4) tick();
    checks++;
    if (state_dbg !== 3'd6 || {dmem_re, dmem_we} !== 2'b00 || bus_err !== 1'b1) begin
      errors++; $display("FAIL both_mem_err: got st=%0d re/we=%b err=%b want st=6 00 1",
                         state_dbg, {dmem_re, dmem_we}, bus_err);
    end
    apply_reset();
  endtask

  task automatic test_step();
    reg_write = 1'b1;
    step = 1'b1;
    tick();
    step = 1'b0;
    checks++;
    if (state_dbg !== 3'd1) begin
      errors++; $display("FAIL step_start: got %0d want 1", state_dbg);
    end
    tick();
    step = 1'b1;  // busy: must be ignored
    tick();
    step = 1'b0;
    tick();
    tick();
    checks++;
    if (state_dbg !== 3'd0 || instret !== 16'd1) begin
      errors++; $display("FAIL step_one: got st=%0d ir=%0d want st=0 ir=1", state_dbg, instret);
    end
    tick();
    checks++;
    if (state_dbg !== 3'd0) begin
      errors++; $display("FAIL step_busy_ignored: got %0d want 0", state_dbg);
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (4) tick();
    checks++;
    if (state_dbg !== 3'd0 || instret !== 16'd2) begin
      errors++; $display("FAIL step_two: got st=%0d ir=%0d want st=0 ir=2", state_dbg, instret);
    end
  endtask

  task automatic test_run_step_together();
    run = 1'b1; step = 1'b1;
    tick();
    step = 1'b0;
    repeat (4) tick();
    checks++;
    if (state_dbg !== 3'd1 || instret !== 16'd3) begin
      errors++; $display("FAIL run_beats_step: got st=%0d ir=%0d want st=1 ir=3", state_dbg, instret);
    end
    run = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_halt_req_async();
    apply_reset();
    run = 1'b1;
    tick();
    tick();
    halt_req = 1'b1;
    tick();
    tick();
    checks++;
    if (pc_en !== 1'b1) begin
      errors++; $display("FAIL halt_req_completes: got %b want 1", pc_en);
    end
    tick();
    tick();
    checks++;
    if (state_dbg !== 3'd0 || instret !== 16'd1) begin
      errors++; $display("FAIL halt_req_stops: got st=%0d ir=%0d want st=0 ir=1", state_dbg, instret);
    end
    halt_req = 1'b0;
    mem_read = 1'b1;
    repeat (4) tick();
    checks++;
    if (dmem_re !== 1'b1) begin
      errors++; $display("FAIL async_pre: got %b want 1", dmem_re);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dmem_re !== 1'b0 || halted !== 1'b1) begin
      errors++; $display("FAIL async_reset_drop: got re=%b halted=%b want 0 1", dmem_re, halted);
    end
    mem_read = 1'b0;
    run = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_jump_branch();
    test_load_wait();
    test_store_timeout();
    test_both_mem();
    test_step();
    test_run_step_together();
    test_halt_req_async();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
